mmc_hex_dump_sequencer: RTL and testbench
=========================================

Name: mmc_hex_dump_sequencer

Overview:
Parametrised multi-block MMC read sequencer with hex text rendering.
- Commands the MMC drive to read a run of consecutive 512-byte blocks, starting from a programmable 32-bit block address.
- Renders every received byte as two ASCII hex characters with attribute bytes into a VRAM text window.
- Configurable row layout and window wrap-around; timeout and error reporting.
- Sits between the MMC drive and the text VGA controller, under a simple start/done control interface.

Parameters:
ADDRESS_WIDTH, 14, VRAM address width.
BASE_ADDRESS, 14'd320, first VRAM cell of the dump window.
WINDOW_SIZE, 14'd4480, window length in VRAM bytes; must be a multiple of ROW_STRIDE.
BYTES_PER_ROW, 16, data bytes rendered per text row (1..32).
ROW_STRIDE, 14'd160, VRAM bytes between row starts; must be ≥ 4×BYTES_PER_ROW.
ATTRIBUTE, 8'h0A, attribute byte written after every character.
ERROR_ATTRIBUTE, 8'h0C, attribute used for bytes of a block that ends in a CRC error.
TIMEOUT, 32'h000FFFF0, max cycles waiting in any drive wait state.

Ports:
clock  in  1  system clock; all state updates on falling edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
start_block  in  32  first block address, sampled on accepted start
block_count  in  8  blocks to read, sampled on accepted start; 0 treated as 256
busy  out  1  high from accepted start until DONE/ERROR exit
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on abort
error_code  out  2  latched cause: 0 none, 1 interface, 2 timeout, 3 crc
blocks_done  out  8  completed block counter
internal_data_bus  out  8  data to drive
write_block_address_1..4  out  1 each  address byte strobes, 1 is LSB
write_access_command  out  1  command strobe; bus 8'h80 = read
read_data  out  1  byte acknowledge / pop
read_data_byte  in  8  current byte from drive
drive_busy  in  1  drive not ready
block_read_interrupt  in  1  byte available
read_completion_interrupt  in  1  block finished
read_interface_error  in  1  drive interface error
read_crc_error  in  1  drive CRC error
chip_select_n  out  1  VRAM select, active-low
write_enable_n  out  1  VRAM write strobe, active-low
address  out  ADDRESS_WIDTH  VRAM address
data_bus_in  out  8  VRAM write data

Behaviour:
- Reset values:
  - All strobes low.
  - chip_select_n and write_enable_n high.
  - Buses 0.
  - busy, done and error at 0; error_code at 0; blocks_done at 0.
  - Cursor at BASE_ADDRESS; state IDLE.
- States: IDLE → FLUSH → ADDR1 → ADDR2 → ADDR3 → ADDR4 → CMD → WAIT → RENDER → ACK → WAIT …; then NEXT_BLOCK, DONE, ERROR.
- FLUSH: read_data=1 every cycle while drive_busy=1; exits to ADDR1 in the first cycle drive_busy=0.
- ADDRn: single cycle with write_block_address_n=1; internal_data_bus carries byte n-1 of (start_block + blocks_done), LSB first.
- CMD: single cycle with write_access_command=1 and internal_data_bus=8'h80.
- WAIT priority:
  1. read_interface_error → ERROR, code 1.
  2. read_completion_interrupt → NEXT_BLOCK; if read_crc_error is set, also latch crc flag.
  3. block_read_interrupt → RENDER.
- RENDER: four VRAM writes, each 2 cycles (cycle 1: chip_select_n=0, write_enable_n=0; cycle 2: chip_select_n=0, write_enable_n=1; address and data stable across both).
  - Write order: hex(hi nibble), attr, hex(lo nibble), attr at cursor+0..+3.
  - Hex encoding: 0-9 → 8'h30+n, A-F → 8'h41+(n-10).
  - Attr is ATTRIBUTE, or ERROR_ATTRIBUTE if read_crc_error is high when the byte is sampled.
  - read_data_byte is captured on RENDER entry.
- ACK: read_data=1 for one cycle; cursor advances by 4. After the BYTES_PER_ROW-th byte of a row, cursor = row_start + ROW_STRIDE.
- Cursor wrap: row_start + ROW_STRIDE ≥ BASE_ADDRESS + WINDOW_SIZE gives cursor = BASE_ADDRESS. Arithmetic is ADDRESS_WIDTH-bit unsigned.
- NEXT_BLOCK:
  - blocks_done increments, 8-bit wrap.
  - If the crc flag is set → ERROR, code 3.
  - Else if blocks_done reaches block_count (0 means 256) → DONE.
  - Else → FLUSH.
- Timeout: a 32-bit counter clears on every state change; reaching TIMEOUT in FLUSH or WAIT → ERROR, code 2.
- DONE / ERROR: single cycle pulsing done or error; then IDLE with busy=0. error_code holds its value until the next accepted start, which clears it to 0.
- start is ignored while busy.
- Cursor persists across runs and is reset only by reset_n.
- Asserting reset_n mid-operation forces all outputs to reset values immediately; no partial VRAM write may complete afterward.

Decomposition:
- Package mmc_hex_dump_pkg:
  - state enum;
  - error_code constants;
  - READ_COMMAND=8'h80;
  - num2ascii function.
- Sub-module mmc_hex_dump_vram_writer:
  - accepts a byte plus attribute with a go pulse;
  - runs the 8-cycle, four-write strobe sequence;
  - returns a one-cycle finish pulse.

Test Plan:
- start_block=32'h00000001, block_count=1, model returns bytes 8'h3C, 8'hF0 then completion → VRAM[320..327] = 33,0A,43,0A,46,0A,30,0A; done pulse; blocks_done=1; error_code=0.
- start_block=32'h12345678 → write_block_address_1..4 carry 78,56,34,12 on consecutive cycles, then command 80.
- BYTES_PER_ROW=16, 17 bytes → byte 17 is written at 320+160=480; with a window filled to the last row, the next row wraps to 320.
- block_count=3, model asserts read_crc_error during block 2 → those bytes use attr 0C; ERROR after block 2 with code 3; blocks_done=2.
- Model never raises interrupts, TIMEOUT=16 → error pulse and code 2 after 16 cycles in WAIT; read_interface_error in WAIT → code 1.
- reset_n low during a RENDER write → chip_select_n and write_enable_n high immediately; a start after release runs cleanly from IDLE.

Source files
------------

// File: rtl/mmc_hex_dump_pkg.sv
// Shared types and helpers for the MMC hex-dump sequencer.
package mmc_hex_dump_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_ADDR1,
      ST_ADDR2,
      ST_ADDR3,
      ST_ADDR4,
      ST_CMD,
      ST_WAIT,
      ST_RENDER,
      ST_ACK,
      ST_NEXT_BLOCK,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_INTERFACE = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
   localparam logic [1:0] ERR_CRC       = 2'd3;

   localparam logic [7:0] READ_COMMAND = 8'h80;

   // Upper-case ASCII hex digit for one nibble.
   function automatic logic [7:0] num2ascii(input logic [3:0] i_nibble);
      if (i_nibble < 4'd10) begin
         return 8'h30 + {4'h0, i_nibble};
      end
      return 8'h37 + {4'h0, i_nibble};
   endfunction

endpackage

// File: rtl/mmc_hex_dump_vram_writer.sv
// Writes one rendered byte (hi hex, attr, lo hex, attr) into four consecutive
// VRAM cells; each cell takes two cycles: strobe low, then strobe high with
// address and data held.
module mmc_hex_dump_vram_writer
   import mmc_hex_dump_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 14
)
(
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_go,
   input  logic [7:0]               i_byte,
   input  logic [7:0]               i_attr,
   input  logic [ADDRESS_WIDTH-1:0] i_base,
   output logic                     o_finish,
   output logic                     o_chip_select_n,
   output logic                     o_write_enable_n,
   output logic [ADDRESS_WIDTH-1:0] o_address,
   output logic [7:0]               o_data
);

   logic                     r_active;
   logic [2:0]               r_step;
   logic [7:0]               r_byte;
   logic [7:0]               r_attr;
   logic [ADDRESS_WIDTH-1:0] r_base;
   logic [7:0]               w_cell [4];

   // Even cells carry hex digits (hi nibble first), odd cells the attribute.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cell
         if (gi % 2 == 1) begin : g_attr
            assign w_cell[gi] = r_attr;
         end else begin : g_hex
            assign w_cell[gi] = num2ascii(r_byte[7-2*gi -: 4]);
         end
      end
   endgenerate

   // Step through the 8 strobe cycles after a go pulse; reset aborts at once.
   always_ff @(negedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_active <= 1'b0;
         r_step   <= 3'd0;
         r_byte   <= 8'h00;
         r_attr   <= 8'h00;
         r_base   <= '0;
      end else if (i_go && !r_active) begin
         r_active <= 1'b1;
         r_step   <= 3'd0;
         r_byte   <= i_byte;
         r_attr   <= i_attr;
         r_base   <= i_base;
      end else if (r_active) begin
         r_step <= r_step + 3'd1;
         if (r_step == 3'd7) begin
            r_active <= 1'b0;
         end
      end
   end

   // Strobes and buses derived from the step counter; idle buses read zero.
   always_comb begin
      o_chip_select_n  = 1'b1;
      o_write_enable_n = 1'b1;
      o_address        = '0;
      o_data           = 8'h00;
      o_finish         = 1'b0;
      if (r_active) begin
         o_chip_select_n  = 1'b0;
         o_write_enable_n = r_step[0];
         o_address        = r_base + {{(ADDRESS_WIDTH-2){1'b0}}, r_step[2:1]};
         o_data           = w_cell[r_step[2:1]];
         o_finish         = (r_step == 3'd7);
      end
   end

endmodule

// File: rtl/mmc_hex_dump_sequencer.sv
// Multi-block MMC read sequencer: addresses and commands the drive, then
// renders every received byte as hex text into a wrapping VRAM window.
module mmc_hex_dump_sequencer
   import mmc_hex_dump_pkg::*;
#(
   parameter int                     ADDRESS_WIDTH   = 14,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = 14'd320,
   parameter logic [ADDRESS_WIDTH-1:0] WINDOW_SIZE   = 14'd4480,
   parameter int                     BYTES_PER_ROW   = 16,
   parameter logic [ADDRESS_WIDTH-1:0] ROW_STRIDE    = 14'd160,
   parameter logic [7:0]             ATTRIBUTE       = 8'h0A,
   parameter logic [7:0]             ERROR_ATTRIBUTE = 8'h0C,
   parameter logic [31:0]            TIMEOUT         = 32'h000FFFF0
)
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [31:0]              start_block,
   input  logic [7:0]               block_count,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [1:0]               error_code,
   output logic [7:0]               blocks_done,
   output logic [7:0]               internal_data_bus,
   output logic                     write_block_address_1,
   output logic                     write_block_address_2,
   output logic                     write_block_address_3,
   output logic                     write_block_address_4,
   output logic                     write_access_command,
   output logic                     read_data,
   input  logic [7:0]               read_data_byte,
   input  logic                     drive_busy,
   input  logic                     block_read_interrupt,
   input  logic                     read_completion_interrupt,
   input  logic                     read_interface_error,
   input  logic                     read_crc_error,
   output logic                     chip_select_n,
   output logic                     write_enable_n,
   output logic [ADDRESS_WIDTH-1:0] address,
   output logic [7:0]               data_bus_in
);

   localparam logic [ADDRESS_WIDTH-1:0] WINDOW_END = BASE_ADDRESS + WINDOW_SIZE;
   localparam logic [4:0]               LAST_COL   = 5'(BYTES_PER_ROW - 1);

   state_t                   r_state;
   state_t                   w_state_next;
   logic [31:0]              r_timer;
   logic [31:0]              r_start_block;
   logic [7:0]               r_block_count;
   logic [7:0]               r_blocks_done;
   logic [1:0]               r_error_code;
   logic                     r_crc_flag;
   logic [ADDRESS_WIDTH-1:0] r_cursor;
   logic [ADDRESS_WIDTH-1:0] r_row_start;
   logic [4:0]               r_col;

   logic                     w_accept;
   logic                     w_set_crc;
   logic                     w_go;
   logic                     w_read_data;
   logic [3:0]               w_addr_strobe;
   logic                     w_cmd;
   logic [7:0]               w_bus;
   logic [1:0]               w_fail_code;
   logic                     w_timed_out;
   logic                     w_wr_finish;
   logic [7:0]               w_blocks_inc;
   logic [31:0]              w_blk_addr;
   logic [7:0]               w_blk_byte [4];
   logic [ADDRESS_WIDTH-1:0] w_row_next;
   logic [7:0]               w_attr;

   assign w_timed_out  = (r_timer + 32'd1) >= TIMEOUT;
   assign w_blocks_inc = r_blocks_done + 8'd1;
   assign w_blk_addr   = r_start_block + {24'h000000, r_blocks_done};
   assign w_row_next   = r_row_start + ROW_STRIDE;
   assign w_attr       = read_crc_error ? ERROR_ATTRIBUTE : ATTRIBUTE;

   // Block address bytes presented LSB first on the four address strobes.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_blk_byte
         assign w_blk_byte[gi] = w_blk_addr[8*gi +: 8];
      end
   endgenerate

   mmc_hex_dump_vram_writer #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_writer (
      .i_clock          (clock),
      .i_reset_n        (reset_n),
      .i_go             (w_go),
      .i_byte           (read_data_byte),
      .i_attr           (w_attr),
      .i_base           (r_cursor),
      .o_finish         (w_wr_finish),
      .o_chip_select_n  (chip_select_n),
      .o_write_enable_n (write_enable_n),
      .o_address        (address),
      .o_data           (data_bus_in)
   );

   // State register plus wait-state timer that restarts on every transition.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_timer <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_timer <= (w_state_next != r_state) ? 32'd0 : r_timer + 32'd1;
      end
   end

   // Next-state decode and drive-side strobes.
   always_comb begin
      w_state_next  = r_state;
      w_fail_code   = ERR_NONE;
      w_accept      = 1'b0;
      w_set_crc     = 1'b0;
      w_go          = 1'b0;
      w_read_data   = 1'b0;
      w_addr_strobe = 4'b0000;
      w_cmd         = 1'b0;
      w_bus         = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (drive_busy) begin
               w_read_data = 1'b1;
               if (w_timed_out) begin
                  w_state_next = ST_ERROR;
                  w_fail_code  = ERR_TIMEOUT;
               end
            end else begin
               w_state_next = ST_ADDR1;
            end
         end
         ST_ADDR1: begin
            w_addr_strobe[0] = 1'b1;
            w_bus            = w_blk_byte[0];
            w_state_next     = ST_ADDR2;
         end
         ST_ADDR2: begin
            w_addr_strobe[1] = 1'b1;
            w_bus            = w_blk_byte[1];
            w_state_next     = ST_ADDR3;
         end
         ST_ADDR3: begin
            w_addr_strobe[2] = 1'b1;
            w_bus            = w_blk_byte[2];
            w_state_next     = ST_ADDR4;
         end
         ST_ADDR4: begin
            w_addr_strobe[3] = 1'b1;
            w_bus            = w_blk_byte[3];
            w_state_next     = ST_CMD;
         end
         ST_CMD: begin
            w_cmd        = 1'b1;
            w_bus        = READ_COMMAND;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (read_interface_error) begin
               w_state_next = ST_ERROR;
               w_fail_code  = ERR_INTERFACE;
            end else if (read_completion_interrupt) begin
               w_state_next = ST_NEXT_BLOCK;
               w_set_crc    = read_crc_error;
            end else if (block_read_interrupt) begin
               w_state_next = ST_RENDER;
               w_go         = 1'b1;
            end else if (w_timed_out) begin
               w_state_next = ST_ERROR;
               w_fail_code  = ERR_TIMEOUT;
            end
         end
         ST_RENDER: begin
            if (w_wr_finish) begin
               w_state_next = ST_ACK;
            end
         end
         ST_ACK: begin
            w_read_data  = 1'b1;
            w_state_next = ST_WAIT;
         end
         ST_NEXT_BLOCK: begin
            if (r_crc_flag) begin
               w_state_next = ST_ERROR;
               w_fail_code  = ERR_CRC;
            end else if (w_blocks_inc == r_block_count) begin
               // 8-bit compare also covers block_count 0 meaning 256 blocks.
               w_state_next = ST_DONE;
            end else begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_DONE:  w_state_next = ST_IDLE;
         ST_ERROR: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Run parameters, progress counters, error cause and the text cursor.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_start_block <= 32'd0;
         r_block_count <= 8'd0;
         r_blocks_done <= 8'd0;
         r_error_code  <= ERR_NONE;
         r_crc_flag    <= 1'b0;
         r_cursor      <= BASE_ADDRESS;
         r_row_start   <= BASE_ADDRESS;
         r_col         <= 5'd0;
      end else begin
         if (w_accept) begin
            r_start_block <= start_block;
            r_block_count <= block_count;
            r_blocks_done <= 8'd0;
            r_error_code  <= ERR_NONE;
            r_crc_flag    <= 1'b0;
         end
         if (w_set_crc) begin
            r_crc_flag <= 1'b1;
         end
         if (r_state == ST_NEXT_BLOCK) begin
            r_blocks_done <= w_blocks_inc;
         end
         if (w_state_next == ST_ERROR && r_state != ST_ERROR) begin
            r_error_code <= w_fail_code;
         end
         if (r_state == ST_ACK) begin
            if (r_col == LAST_COL) begin
               r_col <= 5'd0;
               if (w_row_next >= WINDOW_END) begin
                  r_row_start <= BASE_ADDRESS;
                  r_cursor    <= BASE_ADDRESS;
               end else begin
                  r_row_start <= w_row_next;
                  r_cursor    <= w_row_next;
               end
            end else begin
               r_col    <= r_col + 5'd1;
               r_cursor <= r_cursor + ADDRESS_WIDTH'(4);
            end
         end
      end
   end

   assign busy                  = (r_state != ST_IDLE);
   assign done                  = (r_state == ST_DONE);
   assign error                 = (r_state == ST_ERROR);
   assign error_code            = r_error_code;
   assign blocks_done           = r_blocks_done;
   assign internal_data_bus     = w_bus;
   assign write_block_address_1 = w_addr_strobe[0];
   assign write_block_address_2 = w_addr_strobe[1];
   assign write_block_address_3 = w_addr_strobe[2];
   assign write_block_address_4 = w_addr_strobe[3];
   assign write_access_command  = w_cmd;
   assign read_data             = w_read_data;

endmodule

// File: tb/tb_mmc_hex_dump_sequencer.sv
// Scoreboard bench: tests push expected VRAM writes, drive strobes and
// completion status; a monitor pops and compares as the DUT presents them.
module tb_mmc_hex_dump_sequencer;

   typedef struct packed { logic [13:0] addr; logic [7:0] data; } vram_exp_t;
   typedef struct packed { logic [2:0] kind; logic [7:0] data; } cmd_exp_t;
   typedef struct packed { logic is_err; logic [1:0] code; logic [7:0] bd; } stat_exp_t;

   logic        clock, reset_n, start;
   logic [31:0] start_block;
   logic [7:0]  block_count;
   logic        busy, done, error;
   logic [1:0]  error_code;
   logic [7:0]  blocks_done, internal_data_bus;
   logic        write_block_address_1, write_block_address_2;
   logic        write_block_address_3, write_block_address_4;
   logic        write_access_command, read_data;
   logic [7:0]  read_data_byte;
   logic        drive_busy, block_read_interrupt, read_completion_interrupt;
   logic        read_interface_error, read_crc_error;
   logic        chip_select_n, write_enable_n;
   logic [13:0] address;
   logic [7:0]  data_bus_in;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_strobe_cyc = 0;
   int cmd_cyc = 0;
   int err_cyc = 0;

   vram_exp_t q_vram[$];
   cmd_exp_t  q_cmd[$];
   stat_exp_t q_stat[$];

   // Drive model control: mode 0 normal, 1 silent, 2 interface error.
   int          m_mode = 0;
   int          m_len[$];
   bit          m_crc[$];
   logic [7:0]  m_data[$];
   int          m_left = 0;
   int          comp_hold = 0;

   mmc_hex_dump_sequencer #(.TIMEOUT(32'd16)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .start_block(start_block), .block_count(block_count),
      .busy(busy), .done(done), .error(error), .error_code(error_code),
      .blocks_done(blocks_done), .internal_data_bus(internal_data_bus),
      .write_block_address_1(write_block_address_1),
      .write_block_address_2(write_block_address_2),
      .write_block_address_3(write_block_address_3),
      .write_block_address_4(write_block_address_4),
      .write_access_command(write_access_command), .read_data(read_data),
      .read_data_byte(read_data_byte), .drive_busy(drive_busy),
      .block_read_interrupt(block_read_interrupt),
      .read_completion_interrupt(read_completion_interrupt),
      .read_interface_error(read_interface_error),
      .read_crc_error(read_crc_error),
      .chip_select_n(chip_select_n), .write_enable_n(write_enable_n),
      .address(address), .data_bus_in(data_bus_in)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] hexch(input logic [3:0] n);
      string hs;
      hs = "0123456789ABCDEF";
      return hs[n];
   endfunction

   task automatic push_byte(input int addr, input logic [7:0] b, input logic [7:0] attr);
      q_vram.push_back({14'(addr),     hexch(b[7:4])});
      q_vram.push_back({14'(addr + 1), attr});
      q_vram.push_back({14'(addr + 2), hexch(b[3:0])});
      q_vram.push_back({14'(addr + 3), attr});
   endtask

   task automatic push_cmd(input logic [31:0] blk);
      for (int i = 0; i < 4; i++) q_cmd.push_back({3'(i + 1), blk[8*i +: 8]});
      q_cmd.push_back({3'd5, 8'h80});
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_cs_n"}, 32'(chip_select_n), 32'd1);
      check({tag, "_we_n"}, 32'(write_enable_n), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done_error"}, {30'd0, done, error}, 32'd0);
      check({tag, "_error_code"}, 32'(error_code), 32'd0);
      check({tag, "_blocks_done"}, 32'(blocks_done), 32'd0);
      check({tag, "_strobes"}, {26'd0, write_block_address_1, write_block_address_2,
            write_block_address_3, write_block_address_4, write_access_command, read_data}, 32'd0);
      check({tag, "_buses"}, {2'd0, address, data_bus_in, internal_data_bus}, 32'd0);
   endtask

   task automatic apply_reset();
      @(posedge clock);
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 check_reset_state("reset");
      reset_n = 1'b1;
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_vram_left"}, 32'(q_vram.size()), 32'd0);
      check({tag, "_cmd_left"}, 32'(q_cmd.size()), 32'd0);
      check({tag, "_stat_left"}, 32'(q_stat.size()), 32'd0);
   endtask

   task automatic run(input string tag, input logic [31:0] sb, input logic [7:0] bc,
                      input int limit, input bit poke);
      @(posedge clock);
      #1 start_block = sb; block_count = bc; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      for (int i = 0; i < limit && busy; i++) begin
         @(posedge clock);
         #1;
         if (poke && i == 20) begin
            start = 1'b1; start_block = 32'hDEADBEEF; block_count = 8'd7;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_finished"}, 32'(busy), 32'd0);
      repeat (3) @(posedge clock);
      check_drained(tag);
   endtask

   // Drive model: answers the command with bytes, then a completion pulse.
   task automatic present_next();
      if (m_left > 0) begin
         read_data_byte = m_data.pop_front();
         block_read_interrupt = 1'b1;
         m_left--;
      end else begin
         block_read_interrupt = 1'b0;
         read_completion_interrupt = 1'b1;
         comp_hold = 2;
      end
   endtask

   initial begin
      drive_busy = 1'b0; block_read_interrupt = 1'b0; read_completion_interrupt = 1'b0;
      read_interface_error = 1'b0; read_crc_error = 1'b0; read_data_byte = 8'h00;
      forever begin
         @(posedge clock);
         if (!reset_n) begin
            block_read_interrupt = 1'b0; read_completion_interrupt = 1'b0;
            read_interface_error = 1'b0; read_crc_error = 1'b0;
            comp_hold = 0; m_left = 0;
            m_data.delete(); m_len.delete(); m_crc.delete();
            continue;
         end
         if (m_mode != 2) read_interface_error = 1'b0;
         if (comp_hold > 0) begin
            comp_hold--;
            if (comp_hold == 0) begin
               read_completion_interrupt = 1'b0;
               read_crc_error = 1'b0;
            end
         end
         if (write_access_command) begin
            if (m_mode == 2) begin
               read_interface_error = 1'b1;
            end else if (m_mode == 0 && m_len.size() > 0) begin
               m_left = m_len.pop_front();
               read_crc_error = m_crc.pop_front();
               present_next();
            end
         end else if (read_data && block_read_interrupt) begin
            present_next();
         end
      end
   end

   // Monitor: compares every VRAM write, drive strobe and status pulse.
   initial begin
      vram_exp_t ev;
      cmd_exp_t  ec;
      stat_exp_t es;
      logic [2:0] kind;
      forever begin
         @(posedge clock);
         cyc++;
         if (reset_n) begin
            if (!chip_select_n && !write_enable_n) begin
               if (q_vram.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL vram_unexpected: got addr %0d data %h, expected no write", address, data_bus_in);
               end else begin
                  ev = q_vram.pop_front();
                  check("vram_addr", 32'(address), 32'(ev.addr));
                  check("vram_data", 32'(data_bus_in), 32'(ev.data));
               end
            end
            kind = 3'd0;
            if (write_block_address_1)      kind = 3'd1;
            else if (write_block_address_2) kind = 3'd2;
            else if (write_block_address_3) kind = 3'd3;
            else if (write_block_address_4) kind = 3'd4;
            else if (write_access_command)  kind = 3'd5;
            if (kind != 3'd0) begin
               if (q_cmd.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL strobe_unexpected: got kind %0d bus %h, expected none", kind, internal_data_bus);
               end else begin
                  ec = q_cmd.pop_front();
                  check("strobe_kind", 32'(kind), 32'(ec.kind));
                  check("strobe_bus", 32'(internal_data_bus), 32'(ec.data));
                  if (kind > 3'd1) check("strobe_spacing", 32'(cyc - last_strobe_cyc), 32'd1);
               end
               last_strobe_cyc = cyc;
               if (kind == 3'd5) cmd_cyc = cyc;
            end
            if (done || error) begin
               if (error) err_cyc = cyc;
               if (q_stat.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL status_unexpected: got done %b error %b, expected none", done, error);
               end else begin
                  es = q_stat.pop_front();
                  check("status_kind", {30'd0, done, error}, {30'd0, ~es.is_err, es.is_err});
                  check("status_code", 32'(error_code), 32'(es.code));
                  check("status_blocks_done", 32'(blocks_done), 32'(es.bd));
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] b;
      int seen;
      reset_n = 1'b0; start = 1'b0; start_block = 32'd0; block_count = 8'd0;
      repeat (3) @(posedge clock);
      #1 check_reset_state("por");
      reset_n = 1'b1;

      // T1: two bytes into the first cells of the window.
      m_mode = 0;
      m_len.push_back(2); m_crc.push_back(1'b0);
      m_data.push_back(8'h3C); m_data.push_back(8'hF0);
      push_cmd(32'h00000001);
      q_vram.push_back({14'd320, 8'h33}); q_vram.push_back({14'd321, 8'h0A});
      q_vram.push_back({14'd322, 8'h43}); q_vram.push_back({14'd323, 8'h0A});
      q_vram.push_back({14'd324, 8'h46}); q_vram.push_back({14'd325, 8'h0A});
      q_vram.push_back({14'd326, 8'h30}); q_vram.push_back({14'd327, 8'h0A});
      q_stat.push_back({1'b0, 2'd0, 8'd1});
      run("t1", 32'h00000001, 8'd1, 200, 1'b0);

      // T2: address byte order; cursor carries on from T1.
      m_len.push_back(1); m_crc.push_back(1'b0); m_data.push_back(8'h7E);
      push_cmd(32'h12345678);
      q_vram.push_back({14'd328, 8'h37}); q_vram.push_back({14'd329, 8'h0A});
      q_vram.push_back({14'd330, 8'h45}); q_vram.push_back({14'd331, 8'h0A});
      q_stat.push_back({1'b0, 2'd0, 8'd1});
      run("t2", 32'h12345678, 8'd1, 200, 1'b0);

      // T3: row stepping (byte 16 at 480) and window wrap back to 320.
      apply_reset();
      m_len.push_back(449); m_crc.push_back(1'b0);
      push_cmd(32'h00000040);
      for (int k = 0; k < 449; k++) begin
         b = 8'(k) ^ 8'h5A;
         m_data.push_back(b);
         push_byte(320 + 160 * ((k / 16) % 28) + 4 * (k % 16), b, 8'h0A);
      end
      q_stat.push_back({1'b0, 2'd0, 8'd1});
      run("t3", 32'h00000040, 8'd1, 6000, 1'b0);

      // T4: CRC error in block 2 of 3, with an ignored start while busy.
      apply_reset();
      m_len.push_back(2); m_crc.push_back(1'b0);
      m_len.push_back(2); m_crc.push_back(1'b1);
      m_data.push_back(8'hA5); m_data.push_back(8'h5A);
      m_data.push_back(8'h11); m_data.push_back(8'hEE);
      push_cmd(32'h00000100); push_cmd(32'h00000101);
      push_byte(320, 8'hA5, 8'h0A); push_byte(324, 8'h5A, 8'h0A);
      push_byte(328, 8'h11, 8'h0C); push_byte(332, 8'hEE, 8'h0C);
      q_stat.push_back({1'b1, 2'd3, 8'd2});
      run("t4", 32'h00000100, 8'd3, 400, 1'b1);
      check("t4_code_held", 32'(error_code), 32'd3);

      // T5: silent drive, timeout after 16 cycles in WAIT.
      m_mode = 1;
      push_cmd(32'h00000000);
      q_stat.push_back({1'b1, 2'd2, 8'd0});
      run("t5", 32'h00000000, 8'd1, 200, 1'b0);
      check("t5_timeout_latency", 32'(err_cyc - cmd_cyc), 32'd17);

      // T6: interface error while waiting.
      m_mode = 2;
      push_cmd(32'h00000005);
      q_stat.push_back({1'b1, 2'd1, 8'd0});
      run("t6", 32'h00000005, 8'd2, 200, 1'b0);
      check("t6_code_held", 32'(error_code), 32'd1);
      m_mode = 0;
      repeat (2) @(posedge clock);

      // T7: reset during a RENDER write aborts it cleanly.
      m_len.push_back(1); m_crc.push_back(1'b0); m_data.push_back(8'hC4);
      push_cmd(32'h00000009);
      q_vram.push_back({14'd336, 8'h43});
      @(posedge clock);
      #1 start_block = 32'h00000009; block_count = 8'd1; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      check("t7_code_cleared", 32'(error_code), 32'd0);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         if (!chip_select_n && !write_enable_n) begin
            seen = 1;
            break;
         end
      end
      check("t7_write_seen", 32'(seen), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_state("t7_midreset");
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clock);
      check_drained("t7");

      // T8: clean run after the mid-operation reset.
      m_len.push_back(1); m_crc.push_back(1'b0); m_data.push_back(8'h9B);
      push_cmd(32'h00000002);
      q_vram.push_back({14'd320, 8'h39}); q_vram.push_back({14'd321, 8'h0A});
      q_vram.push_back({14'd322, 8'h42}); q_vram.push_back({14'd323, 8'h0A});
      q_stat.push_back({1'b0, 2'd0, 8'd1});
      run("t8", 32'h00000002, 8'd1, 200, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
